// File: rtl/led_pio_sched.sv
// Heartbeat generator and round-robin sharer of the 2-bit LED PIO between two clients.
// Latency: request or tick seen at edge N drives a single-cycle PIO write (and ack) in cycle N+1.
// Backpressure: clients hold req until ack; req is ignored in WRITE; heartbeat ticks lost to clients or HOLD are dropped.
module led_pio_sched #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_req,
  input  logic [1:0] i_req0_data,
  input  logic [1:0] i_req1_data,
  output logic [1:0] o_ack,
  output logic [1:0] o_pio_address,
  output logic       o_pio_chipselect,
  output logic       o_pio_write_n,
  output logic [1:0] o_pio_writedata,
  output logic       o_busy,
  output logic [1:0] o_led_shadow
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_tick_cnt;
  logic            w_tick;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_nxt;
  logic            r_rr;
  logic            r_hb_phase;
  logic            r_client;
  logic            w_grant;
  logic            w_grant_idx;
  logic            w_hb_go;
  logic            w_wr_go;
  logic [1:0]      w_wr_dat;

  assign w_tick  = (r_tick_cnt == TICK_LAST);
  assign w_wr_go = w_grant | w_hb_go;

  // Free-running prescaler; only reset ever clears it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CW'(1);
    end
  end

  // Next-state, arbitration and hold countdown; client requests beat a same-cycle tick.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_grant     = 1'b0;
    w_hb_go     = 1'b0;
    // Lone req[1] picks 1, lone req[0] picks 0, both pick the round-robin pointer.
    w_grant_idx = i_req[1] & (~i_req[0] | r_rr);
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_WRITE;
        end else if (w_tick && i_enable) begin
          w_hb_go     = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_client && (HOLD_TICKS != 0)) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = HOLD_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (|i_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_WRITE;
        end else if (w_tick) begin
          w_hold_nxt = r_hold_cnt - HW'(1);
          if (r_hold_cnt == HW'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_grant) begin
      w_wr_dat = w_grant_idx ? i_req1_data : i_req0_data;
    end else begin
      w_wr_dat = r_hb_phase ? 2'b10 : 2'b01;
    end
  end

  // State and hold counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Registered PIO strobe/data/ack for the WRITE cycle, plus shadow, phase and pointer updates.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pio_address    <= 2'b00;
      o_pio_chipselect <= 1'b0;
      o_pio_write_n    <= 1'b1;
      o_pio_writedata  <= 2'b00;
      o_ack            <= 2'b00;
      o_busy           <= 1'b0;
      o_led_shadow     <= 2'b00;
      r_rr             <= 1'b0;
      r_hb_phase       <= 1'b0;
      r_client         <= 1'b0;
    end else begin
      o_pio_address    <= 2'b00;
      o_pio_chipselect <= w_wr_go;
      o_pio_write_n    <= ~w_wr_go;
      o_busy           <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        o_ack <= w_grant_idx ? 2'b10 : 2'b01;
      end else begin
        o_ack <= 2'b00;
      end
      if (w_wr_go) begin
        o_pio_writedata <= w_wr_dat;
        r_client        <= w_grant;
      end
      if (w_grant) begin
        r_rr <= ~w_grant_idx;
      end
      // The write completes at the end of the WRITE cycle.
      if (r_state == S_WRITE) begin
        o_led_shadow <= o_pio_writedata;
        if (!r_client) begin
          r_hb_phase <= ~r_hb_phase;
        end
      end
    end
  end

endmodule
